param_digital_lock: RTL and testbench
=====================================

Name: param_digital_lock

Overview:
Parametrised successor to the fixed 4-digit keypad lock. The digit count, digit width, default code, fail limit and lockout duration are all parameters. The code can be reprogrammed at runtime while the lock is open. The full code is evaluated only after the last digit, so entry gives no early hint of which digit was wrong. Repeated failures trigger a timed lockout. Sits between the keypad debouncer/encoder and the door actuator driver.

Parameters:
NUM_DIGITS, 4, digits per code (>=1)
DIGIT_W, 4, bits per digit
DEFAULT_CODE, 16'h4321, reset code (NUM_DIGITS*DIGIT_W bits); MS digit is entered first
MAX_FAILS, 3, consecutive failed attempts that trigger lockout (>=1)
LOCKOUT_CYCLES, 16, clock cycles spent in lockout (>=1)
TIMEOUT_CYCLES, 64, inter-digit timeout; used only with INPUT_TIMEOUT_EN

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
digit_in  input  DIGIT_W  digit value, sampled when load=1
load  input  1  one-cycle strobe entering digit_in
relock  input  1  closes the lock; aborts programming
prog_req  input  1  enters PROGRAM mode; honoured only in UNLOCKED
unlocked  output  1  high while in UNLOCKED or PROGRAM
locked_out  output  1  high while in LOCKOUT
fail_pulse  output  1  one-cycle pulse per failed attempt
prog_done  output  1  one-cycle pulse when a new code is committed
digit_count  output  $clog2(NUM_DIGITS+1)  digits entered in the current sequence
fail_count  output  $clog2(MAX_FAILS+1)  consecutive failures

Behaviour:
- All outputs are registered. After reset: state=IDLE, code=DEFAULT_CODE, all outputs 0. Reset overrides any event in the same cycle, including mid-entry, mid-lockout and mid-program.
- States: IDLE, ENTRY, UNLOCKED, PROGRAM, LOCKOUT.
- IDLE: load stores the digit in the entry buffer. Next state is ENTRY, and digit_count becomes 1. Exception: if NUM_DIGITS==1, the single digit is evaluated immediately.
- ENTRY: each load appends a digit. On the load of the NUM_DIGITS-th digit, the full buffer is compared against the code.
  - Match: go to UNLOCKED, clear fail_count. unlocked=1 from the next cycle.
  - Mismatch: pulse fail_pulse and increment fail_count. If the new fail_count==MAX_FAILS, go to LOCKOUT; otherwise go to IDLE.
  - In both cases digit_count returns to 0.
- Digits are compared raw across all DIGIT_W bits; there is no decimal range check.
- LOCKOUT: load is ignored. The state lasts exactly LOCKOUT_CYCLES cycles, then goes to IDLE with fail_count=0.
- UNLOCKED: load is ignored. relock goes to IDLE. prog_req goes to PROGRAM. If relock and prog_req arrive together, relock wins.
- PROGRAM: loads fill a shadow register.
  - After NUM_DIGITS loads: code is replaced by the shadow, prog_done pulses, and the state returns to UNLOCKED.
  - relock in PROGRAM discards the shadow, leaves the code unchanged, and goes to IDLE.
  - A relock arriving in the same cycle as the final load also wins, and the code is unchanged.
- relock is ignored in IDLE, ENTRY and LOCKOUT; partial entries are not cleared by it. prog_req is ignored outside UNLOCKED.
- fail_count saturates at MAX_FAILS.
- Latency: every response appears one cycle after the sampling edge.

Optional Feature:
INPUT_TIMEOUT_EN
- Defined: in ENTRY and PROGRAM, a counter restarts on each load.
  - If TIMEOUT_CYCLES consecutive cycles pass without a load in ENTRY, the partial entry is discarded and the state goes to IDLE. This does not count as a failure and produces no fail_pulse.
  - The same timeout in PROGRAM discards the shadow and returns to UNLOCKED.
- Undefined: partial entries are held indefinitely, TIMEOUT_CYCLES is unused, and no timeout logic is generated.

Decomposition:
- Package param_digital_lock_pkg holds:
  - state encoding localparams (IDLE=0 ... LOCKOUT=4)
  - the state width
  - a function returning the digit slice for index i
- One natural sub-module, lock_cycle_timer: a loadable down-counter with an expiry flag. It is instantiated for the LOCKOUT_CYCLES lockout and, under INPUT_TIMEOUT_EN, for the timeout.

Test Plan:
1. Defaults; load 4,3,2,1 -> unlocked=1 on the cycle after the 4th load; fail_count=0.
2. Load 4,3,2,9 -> no fail_pulse after the 3rd load, so no early fail; fail_pulse one cycle after the 4th load; fail_count=1; state IDLE.
3. Three wrong codes -> locked_out=1 for exactly 16 cycles with loads ignored; then locked_out=0 and fail_count=0; 4,3,2,1 then unlocks.
4. Unlock, prog_req, load 7,7,0,5 -> prog_done pulse; relock; 4,3,2,1 fails and 7,7,0,5 unlocks.
5. PROGRAM with 2 digits entered, then relock -> unlocked=0, code still 4321. Also: relock and prog_req together in UNLOCKED -> IDLE.
6. Reset asserted after 2 digits or mid-lockout -> all outputs 0 on the next cycle and code=DEFAULT_CODE. With INPUT_TIMEOUT_EN: 2 digits, then 64 idle cycles -> digit_count=0 and fail_count unchanged.

Source files
------------

// File: rtl/param_digital_lock_pkg.sv
// Shared definitions for the parametrised keypad lock: state encoding and digit
// slicing helper.
package param_digital_lock_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned MAX_CODE_W  = 256;
    localparam int unsigned MAX_DIGIT_W = 32;

    localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] S_ENTRY    = 3'd1;
    localparam logic [STATE_W-1:0] S_UNLOCKED = 3'd2;
    localparam logic [STATE_W-1:0] S_PROGRAM  = 3'd3;
    localparam logic [STATE_W-1:0] S_LOCKOUT  = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = S_IDLE,
        ST_ENTRY    = S_ENTRY,
        ST_UNLOCKED = S_UNLOCKED,
        ST_PROGRAM  = S_PROGRAM,
        ST_LOCKOUT  = S_LOCKOUT
    } state_e;

    // Digit idx of a code vector; idx 0 is the least significant (last entered) digit.
    function automatic logic [MAX_DIGIT_W-1:0] digit_at(input logic [MAX_CODE_W-1:0] code,
                                                        input int unsigned idx,
                                                        input int unsigned digit_w);
        logic [MAX_CODE_W-1:0]  shifted;
        logic [MAX_DIGIT_W-1:0] mask;
        shifted = code >> (idx * digit_w);
        mask    = (MAX_DIGIT_W'(1) << digit_w) - MAX_DIGIT_W'(1);
        return MAX_DIGIT_W'(shifted) & mask;
    endfunction

endpackage

// File: rtl/param_digital_lock_if.sv
// Keypad-side and actuator-side signals of the lock, bundled with master/slave views.
interface param_digital_lock_if #(
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MAX_FAILS  = 3
);
    localparam int unsigned CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

    logic [DIGIT_W-1:0] digit_in;
    logic               load;
    logic               relock;
    logic               prog_req;
    logic               unlocked;
    logic               locked_out;
    logic               fail_pulse;
    logic               prog_done;
    logic [CNT_W-1:0]   digit_count;
    logic [FAIL_W-1:0]  fail_count;

    modport master (
        output digit_in, load, relock, prog_req,
        input  unlocked, locked_out, fail_pulse, prog_done, digit_count, fail_count
    );

    modport slave (
        input  digit_in, load, relock, prog_req,
        output unlocked, locked_out, fail_pulse, prog_done, digit_count, fail_count
    );

endinterface

// File: rtl/param_digital_lock_timer.sv
// lock_cycle_timer: loadable down-counter; a start makes expired_o rise exactly
// CYCLES-1 cycles later, so the owner leaves its state on the CYCLES-th edge.
module lock_cycle_timer #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             expired_q;

    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = CNT_W'(CYCLES - 1);
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            expired_q <= 1'b1;
        end else begin
            count_q   <= count_d;
            expired_q <= (count_d == '0);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/param_digital_lock.sv
// Parametrised keypad lock with runtime reprogramming and timed lockout.
// Optional inter-digit timeout is built when INPUT_TIMEOUT_EN is defined.
module param_digital_lock
    import param_digital_lock_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DIGIT_W        = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h4321,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    param_digital_lock_if.slave   lock_if
);
    localparam int unsigned CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int unsigned CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

    if (NUM_DIGITS < 1 || MAX_FAILS < 1 || LOCKOUT_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        CODE_W > MAX_CODE_W || DIGIT_W > MAX_DIGIT_W) begin : g_bad_params
        $error("param_digital_lock: unsupported parameter set");
    end

    state_e             state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d, entry_q, entry_d, ins_c;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FAIL_W-1:0]  fails_q, fails_d;
    logic               unlocked_q, locked_out_q;
    logic               fail_pulse_q, fail_pulse_d, prog_done_q, prog_done_d;
    logic               last_c, match_c, lock_start_c, lock_exp_c, tmo_exp_c;

    // Entry/shadow buffer with the incoming digit placed at the current position (MS first).
    always_comb begin
        ins_c = entry_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (cnt_q == CNT_W'(NUM_DIGITS - 1 - i)) ins_c[i*DIGIT_W +: DIGIT_W] = lock_if.digit_in;
        end
    end

    always_comb begin
        match_c = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_at(MAX_CODE_W'(ins_c), i, DIGIT_W) != digit_at(MAX_CODE_W'(code_q), i, DIGIT_W))
                match_c = 1'b0;
        end
    end

    assign last_c       = (cnt_q == CNT_W'(NUM_DIGITS - 1));
    assign lock_start_c = (state_d == ST_LOCKOUT) && (state_q != ST_LOCKOUT);

    lock_cycle_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lockout_timer (
        .clk       (clk),
        .reset     (reset),
        .start_i   (lock_start_c),
        .expired_o (lock_exp_c)
    );

`ifdef INPUT_TIMEOUT_EN
    logic tmo_start_c;
    // Restart on every load; held restarted while UNLOCKED so PROGRAM begins with a full window.
    assign tmo_start_c = lock_if.load || (state_q == ST_UNLOCKED);

    lock_cycle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout_timer (
        .clk       (clk),
        .reset     (reset),
        .start_i   (tmo_start_c),
        .expired_o (tmo_exp_c)
    );
`else
    assign tmo_exp_c = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        entry_d      = entry_q;
        cnt_d        = cnt_q;
        fails_d      = fails_q;
        fail_pulse_d = 1'b0;
        prog_done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (lock_if.load) begin
                    entry_d = ins_c;
                    if (last_c) begin
                        cnt_d = '0;
                        if (match_c) begin
                            state_d = ST_UNLOCKED;
                            fails_d = '0;
                        end else begin
                            fail_pulse_d = 1'b1;
                            if (fails_q >= FAIL_W'(MAX_FAILS - 1)) begin
                                fails_d = FAIL_W'(MAX_FAILS);
                                state_d = ST_LOCKOUT;
                            end else begin
                                fails_d = fails_q + FAIL_W'(1);
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_ENTRY;
                    end
                end else if (state_q == ST_ENTRY && tmo_exp_c) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_UNLOCKED: begin
                if (lock_if.relock) begin
                    state_d = ST_IDLE;
                end else if (lock_if.prog_req) begin
                    cnt_d   = '0;
                    state_d = ST_PROGRAM;
                end
            end
            ST_PROGRAM: begin
                if (lock_if.relock) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (lock_if.load) begin
                    entry_d = ins_c;
                    if (last_c) begin
                        code_d      = ins_c;
                        prog_done_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_UNLOCKED;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (tmo_exp_c) begin
                    cnt_d   = '0;
                    state_d = ST_UNLOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (lock_exp_c) begin
                    fails_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            code_q       <= DEFAULT_CODE;
            entry_q      <= '0;
            cnt_q        <= '0;
            fails_q      <= '0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
            fail_pulse_q <= 1'b0;
            prog_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            entry_q      <= entry_d;
            cnt_q        <= cnt_d;
            fails_q      <= fails_d;
            unlocked_q   <= (state_d == ST_UNLOCKED) || (state_d == ST_PROGRAM);
            locked_out_q <= (state_d == ST_LOCKOUT);
            fail_pulse_q <= fail_pulse_d;
            prog_done_q  <= prog_done_d;
        end
    end

    assign lock_if.unlocked    = unlocked_q;
    assign lock_if.locked_out  = locked_out_q;
    assign lock_if.fail_pulse  = fail_pulse_q;
    assign lock_if.prog_done   = prog_done_q;
    assign lock_if.digit_count = cnt_q;
    assign lock_if.fail_count  = fails_q;

endmodule

// File: tb/tb_param_digital_lock.sv
// Self-checking bench for param_digital_lock: vector table plus hand-written
// lockout, reset and timeout sequences, compared through an expectation queue.
module tb_param_digital_lock;

    localparam int unsigned NUM_DIGITS     = 4;
    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned MAX_FAILS      = 3;
    localparam int unsigned LOCKOUT_CYCLES = 16;
    localparam int unsigned TIMEOUT_CYCLES = 64;

    logic clk;
    logic reset;

    param_digital_lock_if #(.DIGIT_W(DIGIT_W), .NUM_DIGITS(NUM_DIGITS), .MAX_FAILS(MAX_FAILS)) lif ();

    param_digital_lock #(
        .NUM_DIGITS     (NUM_DIGITS),
        .DIGIT_W        (DIGIT_W),
        .DEFAULT_CODE   (16'h4321),
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .lock_if (lif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       unl;
        logic       lo;
        logic       fp;
        logic       pd;
        logic [2:0] dc;
        logic [1:0] fc;
    } out_t;

    typedef enum int {C_NOP, C_LD, C_RL, C_PR, C_RST, C_LDRL, C_RLPR} cmd_e;

    typedef struct {
        cmd_e       cmd;
        logic [3:0] d;
        out_t       e;
    } vec_t;

    vec_t tbl[$];
    out_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    function automatic out_t o(input bit unl, input bit lo, input bit fp, input bit pd,
                               input int dc, input int fc);
        out_t r;
        r.unl = unl; r.lo = lo; r.fp = fp; r.pd = pd;
        r.dc  = 3'(dc);
        r.fc  = 2'(fc);
        return r;
    endfunction

    function automatic void add(input cmd_e c, input int d, input out_t e);
        vec_t v;
        v.cmd = c;
        v.d   = 4'(d);
        v.e   = e;
        tbl.push_back(v);
    endfunction

    // kind 0: correct code, 1: wrong code (no lockout), 2: programming a new code
    function automatic void add_entry(input logic [15:0] code, input int fc, input int kind);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] d;
            d = code[15-4*k -: 4];
            if (k < 3)          add(C_LD, int'(d), o(kind == 2, 0, 0, 0, k + 1, fc));
            else if (kind == 0) add(C_LD, int'(d), o(1, 0, 0, 0, 0, 0));
            else if (kind == 1) add(C_LD, int'(d), o(0, 0, 1, 0, 0, fc + 1));
            else                add(C_LD, int'(d), o(1, 0, 0, 1, 0, fc));
        end
    endfunction

    task automatic apply(input cmd_e c, input logic [3:0] d, input out_t e);
        out_t got;
        out_t want;
        @(negedge clk);
        reset        = (c == C_RST);
        lif.load     = (c == C_LD) || (c == C_LDRL);
        lif.relock   = (c == C_RL) || (c == C_LDRL) || (c == C_RLPR);
        lif.prog_req = (c == C_PR) || (c == C_RLPR);
        lif.digit_in = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = {lif.unlocked, lif.locked_out, lif.fail_pulse, lif.prog_done,
                lif.digit_count, lif.fail_count};
        want = exp_q.pop_front();
        checks++;
        step_no++;
        if (got !== want) begin
            errors++;
            $display("FAIL step %0d: got unl=%b lo=%b fp=%b pd=%b dc=%0d fc=%0d, expected unl=%b lo=%b fp=%b pd=%b dc=%0d fc=%0d",
                     step_no, got.unl, got.lo, got.fp, got.pd, got.dc, got.fc,
                     want.unl, want.lo, want.fp, want.pd, want.dc, want.fc);
        end
    endtask

    task automatic enter_code(input logic [15:0] code, input int fc, input int kind);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] d;
            d = code[15-4*k -: 4];
            if (k < 3)          apply(C_LD, d, o(0, 0, 0, 0, k + 1, fc));
            else if (kind == 0) apply(C_LD, d, o(1, 0, 0, 0, 0, 0));
            else                apply(C_LD, d, o(0, fc + 1 == MAX_FAILS, 1, 0, 0, fc + 1));
        end
    endtask

    task automatic three_fails();
        for (int a = 0; a < 3; a++) enter_code(16'h1111, a, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t z, u;
        reset        = 1'b1;
        lif.load     = 1'b0;
        lif.relock   = 1'b0;
        lif.prog_req = 1'b0;
        lif.digit_in = '0;
        z = o(0, 0, 0, 0, 0, 0);
        u = o(1, 0, 0, 0, 0, 0);

        // reset state and basic unlock; loads ignored while open
        add(C_RST, 0, z); add(C_NOP, 0, z);
        add_entry(16'h4321, 0, 0); add(C_NOP, 0, u); add(C_LD, 5, u); add(C_RL, 0, z);
        // wrong last digit: no early hint, fail after 4th digit
        add_entry(16'h4329, 0, 1); add(C_NOP, 0, o(0, 0, 0, 0, 0, 1));
        add(C_RL, 0, o(0, 0, 0, 0, 0, 1)); add(C_PR, 0, o(0, 0, 0, 0, 0, 1));
        // relock ignored mid-entry; success clears fail_count
        add(C_LD, 4, o(0, 0, 0, 0, 1, 1)); add(C_RL, 0, o(0, 0, 0, 0, 1, 1));
        add(C_LD, 3, o(0, 0, 0, 0, 2, 1)); add(C_LD, 2, o(0, 0, 0, 0, 3, 1)); add(C_LD, 1, u);
        // program 7705
        add(C_PR, 0, u); add_entry(16'h7705, 0, 2); add(C_NOP, 0, u); add(C_RL, 0, z);
        add_entry(16'h4321, 0, 1); add_entry(16'h7705, 1, 0);
        // reset restores the default code
        add(C_RST, 0, z); add_entry(16'h7705, 0, 1); add_entry(16'h4321, 1, 0);
        // relock aborts programming after 2 digits
        add(C_PR, 0, u); add(C_LD, 1, o(1, 0, 0, 0, 1, 0)); add(C_LD, 2, o(1, 0, 0, 0, 2, 0));
        add(C_RL, 0, z); add_entry(16'h4321, 0, 0);
        // relock beats prog_req
        add(C_RLPR, 0, z); add(C_NOP, 0, z); add_entry(16'h4321, 0, 0);
        // relock together with final programming load
        add(C_PR, 0, u); add(C_LD, 9, o(1, 0, 0, 0, 1, 0)); add(C_LD, 9, o(1, 0, 0, 0, 2, 0));
        add(C_LD, 9, o(1, 0, 0, 0, 3, 0)); add(C_LDRL, 9, z);
        add_entry(16'h4321, 0, 0); add(C_RL, 0, z);
        // reset mid-entry
        add(C_LD, 4, o(0, 0, 0, 0, 1, 0)); add(C_LD, 3, o(0, 0, 0, 0, 2, 0)); add(C_RST, 0, z);
        add_entry(16'h4321, 0, 0); add(C_RL, 0, z);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i].cmd, tbl[i].d, tbl[i].e);

        // lockout: high for exactly LOCKOUT_CYCLES cycles, loads ignored throughout
        three_fails();
        for (int i = 1; i < LOCKOUT_CYCLES; i++) apply(C_LD, 4'd4, o(0, 1, 0, 0, 0, 3));
        apply(C_LD, 4'd4, z);
        enter_code(16'h4321, 0, 0);
        apply(C_RL, 4'd0, z);

        // reset mid-lockout
        three_fails();
        for (int i = 0; i < 5; i++) apply(C_NOP, 4'd0, o(0, 1, 0, 0, 0, 3));
        apply(C_RST, 4'd0, z);
        enter_code(16'h4321, 0, 0);
        apply(C_RL, 4'd0, z);

        // idle gap after a partial entry
        enter_code(16'h1111, 0, 1);
        apply(C_LD, 4'd4, o(0, 0, 0, 0, 1, 1));
        apply(C_LD, 4'd3, o(0, 0, 0, 0, 2, 1));
`ifdef INPUT_TIMEOUT_EN
        for (int i = 1; i < TIMEOUT_CYCLES; i++) apply(C_NOP, 4'd0, o(0, 0, 0, 0, 2, 1));
        apply(C_NOP, 4'd0, o(0, 0, 0, 0, 0, 1));
        enter_code(16'h4321, 1, 0);
`else
        for (int i = 0; i < TIMEOUT_CYCLES; i++) apply(C_NOP, 4'd0, o(0, 0, 0, 0, 2, 1));
        apply(C_LD, 4'd2, o(0, 0, 0, 0, 3, 1));
        apply(C_LD, 4'd1, u);
`endif
        apply(C_RL, 4'd0, z);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
